alu_share_arbiter: RTL and testbench

Two-port front end that shares one `alu_64` instance between the execute stage (port 0) and a secondary requester (port 1, address/branch-target unit). Arbitrates round-robin with valid/ready handshakes, registers the 64-bit result and overflow in a one-entry output buffer, and owns the Y86-64 condition-code register (ZF/SF/OF), which only port 0 may update.

---
 rtl/alu_share_arbiter_pkg.sv | 32 +++
 rtl/alu_share_arbiter_if.sv | 47 ++++
 rtl/alu_share_arbiter_alu.sv | 41 ++++
 rtl/alu_share_arbiter.sv | 112 +++++++++++
 tb/tb_alu_share_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the ALU share arbiter: op codes, the
// condition-code record and its reset value.
package alu_share_arbiter_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  // Y86-64 condition codes, packed as {ZF,SF,OF}.
  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

  // Condition codes derived from an ALU result and its overflow flag.
  function automatic cc_t cc_from(input logic [DATA_W-1:0] result, input logic overflow);
    cc_t cc;
    cc.zf = (result == '0);
    cc.sf = result[DATA_W-1];
    cc.of = overflow;
    return cc;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters, the result consumer
// and the arbiter. The arbiter uses the slave view.
interface alu_share_arbiter_if;
  import alu_share_arbiter_pkg::*;

  logic                req0_valid;
  logic                req0_ready;
  alu_op_e             req0_op;
  logic [DATA_W-1:0]   req0_a;
  logic [DATA_W-1:0]   req0_b;
  logic                req0_set_cc;

  logic                req1_valid;
  logic                req1_ready;
  alu_op_e             req1_op;
  logic [DATA_W-1:0]   req1_a;
  logic [DATA_W-1:0]   req1_b;

  logic                resp_valid;
  logic                resp_ready;
  logic                resp_id;
  logic [DATA_W-1:0]   resp_result;
  logic                resp_overflow;

  logic                cc_zf;
  logic                cc_sf;
  logic                cc_of;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_set_cc,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result, resp_overflow,
    output cc_zf, cc_sf, cc_of
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_set_cc,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result, resp_overflow,
    input  cc_zf, cc_sf, cc_of
  );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// alu_64: combinational 64-bit add/sub/and/xor with signed overflow.
module alu_64
  import alu_share_arbiter_pkg::*;
(
  input  alu_op_e             op_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [DATA_W-1:0]   result_o,
  output logic                overflow_o
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              sa;
  logic              sb;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign sa   = a_i[DATA_W-1];
  assign sb   = b_i[DATA_W-1];

  // Select the result and flag overflow when the sign of a wrapped sum/difference is impossible.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    result_o   = '0;
    overflow_o = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (sa == sb) && (sum[DATA_W-1] != sa);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (sa != sb) && (diff[DATA_W-1] != sa);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_XOR: result_o = a_i ^ b_i;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin front end sharing one alu_64 between the execute stage (port 0)
// and the address/branch-target unit (port 1). Holds a one-entry result
// buffer and the condition-code register, which only port 0 may update.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 64  // fixed to match alu_64
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus
);

  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q,    resp_id_d;
  logic [WIDTH-1:0] resp_res_q,   resp_res_d;
  logic             resp_ov_q,    resp_ov_d;
  logic             prio_q,       prio_d;
  cc_t              cc_q,         cc_d;

  logic             free;
  logic             xfer0;
  logic             xfer1;
  alu_op_e          alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov;

  // A port is ready when the buffer can take a result and it holds the grant;
  // the grant looks only at the other port's valid, never its own.
  assign free           = !resp_valid_q || bus.resp_ready;
  assign bus.req0_ready = !rst && free && (!bus.req1_valid || !prio_q);
  assign bus.req1_ready = !rst && free && (!bus.req0_valid ||  prio_q);
  assign xfer0          = bus.req0_valid && bus.req0_ready;
  assign xfer1          = bus.req1_valid && bus.req1_ready;

  // Steer the transferring port's operands into the shared ALU.
  always_comb begin
    alu_op = bus.req0_op;
    alu_a  = bus.req0_a;
    alu_b  = bus.req0_b;
    if (xfer1) begin
      alu_op = bus.req1_op;
      alu_a  = bus.req1_a;
      alu_b  = bus.req1_b;
    end
  end

  alu_64 alu_shared (
    .op_i       (alu_op),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .result_o   (alu_res),
    .overflow_o (alu_ov)
  );

  // Next state: load the buffer on a transfer (overwriting a consumed entry
  // without a bubble), drain it on consume, rotate priority, update CC.
  always_comb begin
    // NOTE: combinational next-state logic uses blocking '='; only the
    // clocked block below uses '<=' so all flops update from the same values.
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    resp_ov_d    = resp_ov_q;
    prio_d       = prio_q;
    cc_d         = cc_q;
    if (xfer0 || xfer1) begin
      resp_valid_d = 1'b1;
      resp_id_d    = xfer1;
      resp_res_d   = alu_res;
      resp_ov_d    = alu_ov;
      prio_d       = xfer0;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
    if (xfer0 && bus.req0_set_cc) begin
      cc_d = cc_from(alu_res, alu_ov);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result fields are reset too because they are visible
      // outputs with defined reset values, not just qualified by resp_valid.
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_res_q   <= '0;
      resp_ov_q    <= 1'b0;
      prio_q       <= 1'b0;
      cc_q         <= CC_RESET;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
      resp_ov_q    <= resp_ov_d;
      prio_q       <= prio_d;
      cc_q         <= cc_d;
    end
  end

  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_result   = resp_res_q;
  assign bus.resp_overflow = resp_ov_q;
  assign bus.cc_zf         = cc_q.zf;
  assign bus.cc_sf         = cc_q.sf;
  assign bus.cc_of         = cc_q.of;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a vector table of single-port
// operations, then hand-written alternation, backpressure and reset sequences.
// Responses are checked against a scoreboard queue filled at transfer time.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  typedef struct {
    logic        port;
    alu_op_e     op;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [63:0] res;
    logic        ov;
    logic [2:0]  cc;   // {ZF,SF,OF} expected after the operation
  } vec_t;

  typedef struct packed {
    logic        id;
    logic [63:0] res;
    logic        ov;
  } resp_t;

  localparam int NV = 11;

  logic  clk;
  logic  rst;
  int    total;
  int    bad;
  vec_t  vecs [NV];
  resp_t sb [$];
  resp_t exp0;
  resp_t exp1;
  resp_t mon_e;

  alu_share_arbiter_if bus ();

  alu_share_arbiter #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] cc_now();
    return {61'd0, bus.cc_zf, bus.cc_sf, bus.cc_of};
  endfunction

  task automatic set_req0(input logic v, input alu_op_e op, input logic [63:0] a,
                          input logic [63:0] b, input logic set_cc,
                          input logic [63:0] res, input logic ov);
    bus.req0_valid  = v;
    bus.req0_op     = op;
    bus.req0_a      = a;
    bus.req0_b      = b;
    bus.req0_set_cc = set_cc;
    exp0            = '{1'b0, res, ov};
  endtask

  task automatic set_req1(input logic v, input alu_op_e op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] res, input logic ov);
    bus.req1_valid = v;
    bus.req1_op    = op;
    bus.req1_a     = a;
    bus.req1_b     = b;
    exp1           = '{1'b1, res, ov};
  endtask

  // Monitor: compare consumed results, then record new transfers.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got result %h with nothing expected", bus.resp_result);
        end else begin
          mon_e = sb.pop_front();
          check("resp_id",       {63'd0, bus.resp_id},       {63'd0, mon_e.id});
          check("resp_result",   bus.resp_result,            mon_e.res);
          check("resp_overflow", {63'd0, bus.resp_overflow}, {63'd0, mon_e.ov});
        end
      end
      if (bus.req0_valid && bus.req0_ready) sb.push_back(exp0);
      if (bus.req1_valid && bus.req1_ready) sb.push_back(exp1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{1'b0, ALU_ADD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 64'd0, 1'b0, 3'b100};
    vecs[1]  = '{1'b0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 3'b011};
    vecs[2]  = '{1'b0, ALU_SUB, 64'd1, 64'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b011};
    vecs[3]  = '{1'b1, ALU_AND, 64'hFF, 64'h0F, 1'b0, 64'h0F, 1'b0, 3'b011};
    vecs[4]  = '{1'b0, ALU_XOR, 64'hFF, 64'hFF, 1'b1, 64'd0, 1'b0, 3'b100};
    vecs[5]  = '{1'b0, ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b001};
    vecs[6]  = '{1'b1, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b0, 3'b001};
    vecs[7]  = '{1'b0, ALU_AND, 64'hF0F0, 64'hFF00, 1'b1, 64'hF000, 1'b0, 3'b000};
    vecs[8]  = '{1'b0, ALU_SUB, 64'd5, 64'd5, 1'b1, 64'd0, 1'b0, 3'b100};
    vecs[9]  = '{1'b0, ALU_ADD, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 1'b1, 3'b101};
    vecs[10] = '{1'b1, ALU_SUB, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b101};

    rst = 1'b1;
    set_req0(1'b0, ALU_ADD, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
    set_req1(1'b0, ALU_ADD, 64'd0, 64'd0, 64'd0, 1'b0);
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", {63'd0, bus.resp_valid},    64'd0);
    check("rst_resp_id",    {63'd0, bus.resp_id},       64'd0);
    check("rst_resp_res",   bus.resp_result,            64'd0);
    check("rst_resp_ov",    {63'd0, bus.resp_overflow}, 64'd0);
    check("rst_cc",         cc_now(),                   64'b100);

    // Single-port vectors, one at a time with the consumer always ready.
    for (int i = 0; i < NV; i++) begin
      step();
      if (vecs[i].port == 1'b0)
        set_req0(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].set_cc, vecs[i].res, vecs[i].ov);
      else
        set_req1(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ov);
      @(negedge clk);
      check("vec_ready", {63'd0, (vecs[i].port ? bus.req1_ready : bus.req0_ready)}, 64'd1);
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      check("vec_cc", cc_now(), {61'd0, vecs[i].cc});
    end

    // Both ports valid every cycle: grants alternate starting with port 0.
    step();
    set_req0(1'b1, ALU_SUB, 64'd10, 64'd3, 1'b1, 64'd7, 1'b0);
    set_req1(1'b1, ALU_XOR, 64'hF0, 64'hFF, 64'h0F, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("alt_ready0", {63'd0, bus.req0_ready}, {63'd0, (k % 2 == 0)});
      check("alt_ready1", {63'd0, bus.req1_ready}, {63'd0, (k % 2 == 1)});
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("alt_cc", cc_now(), 64'b000);

    // Backpressure: buffer holds 5 while both ports wait, then a port-1
    // transfer replaces it in the same cycle it is consumed.
    step();
    bus.resp_ready = 1'b0;
    set_req0(1'b1, ALU_ADD, 64'd2, 64'd3, 1'b0, 64'd5, 1'b0);
    step();
    set_req1(1'b1, ALU_AND, 64'hFF, 64'h0F, 64'h0F, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready0",     {63'd0, bus.req0_ready}, 64'd0);
      check("bp_ready1",     {63'd0, bus.req1_ready}, 64'd0);
      check("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
      check("bp_resp_res",   bus.resp_result,         64'd5);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready1", {63'd0, bus.req1_ready}, 64'd1);
    step();
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("bp_nogap_valid", {63'd0, bus.resp_valid}, 64'd1);
    check("bp_nogap_res",   bus.resp_result,         64'h0F);
    check("bp_cc",          cc_now(),                64'b000);

    // Reset while a result is buffered and both ports are requesting.
    step();
    bus.resp_ready = 1'b0;
    set_req0(1'b1, ALU_SUB, 64'd1, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step();
    check("pre_rst_valid", {63'd0, bus.resp_valid}, 64'd1);
    check("pre_rst_cc",    cc_now(),                64'b010);
    set_req0(1'b1, ALU_ADD, 64'd4, 64'd4, 1'b1, 64'd8, 1'b0);
    set_req1(1'b1, ALU_XOR, 64'h3, 64'h1, 64'h2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("in_rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    check("in_rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    sb.delete();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid",  {63'd0, bus.resp_valid}, 64'd0);
    check("post_rst_cc",     cc_now(),                64'b100);
    check("post_rst_ready0", {63'd0, bus.req0_ready}, 64'd1);
    check("post_rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("post_rst_id",  {63'd0, bus.resp_id}, 64'd0);
    check("post_rst_cc2", cc_now(),             64'b000);

    repeat (2) step();
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
